// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

  // Widest address the captured-request struct can carry.
  localparam int MAX_AW           = 64;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_e;

  // Request fields held stable toward memory while a transaction is in flight.
  typedef struct packed {
    logic [MAX_AW-1:0] addr;
    logic              we;
    logic [63:0]       wdata;
    logic [7:0]        wstrb;
  } mem_req_t;

  // Memory is addressed in doublewords; drop the byte offset.
  function automatic logic [MAX_AW-1:0] dw_align(input logic [MAX_AW-1:0] addr);
    return {addr[MAX_AW-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between instruction fetch and load/store.
// One transaction in flight; data wins by default, fetch wins once it has
// been blocked STARVE_LIMIT consecutive cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int AW           = 64
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          if_req_valid,
  output logic          if_req_ready,
  input  logic [AW-1:0] if_addr,
  output logic          if_rsp_valid,
  output logic [31:0]   if_rsp_data,

  input  logic          d_req_valid,
  output logic          d_req_ready,
  input  logic [AW-1:0] d_addr,
  input  logic          d_we,
  input  logic [63:0]   d_wdata,
  input  logic [7:0]    d_wstrb,
  output logic          d_rsp_valid,
  output logic [63:0]   d_rsp_data,

  output logic          m_req_valid,
  input  logic          m_req_ready,
  output logic [AW-1:0] m_addr,
  output logic          m_we,
  output logic [63:0]   m_wdata,
  output logic [7:0]    m_wstrb,
  input  logic          m_rsp_valid,
  input  logic [63:0]   m_rsp_data,

  output logic          err
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  state_e        state, state_nxt;
  owner_e        owner;
  mem_req_t      req_q;
  mem_req_t      req_nxt;
  logic [CW-1:0] starve_cnt;
  logic          grant_if;
  logic          if_acc, d_acc;
  logic          rsp_fire;
  logic [MAX_AW-1:0] m_addr_full;

  // Grant: fetch wins when alone, or when both request and fetch is starved.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    grant_if     = 1'b0;
    if (if_req_valid && (!d_req_valid || starve_cnt == LIMIT)) grant_if = 1'b1;
    // Readies are gated by reset so they fall with rst, not at the next edge.
    if_req_ready = rst && (state == IDLE) && if_req_valid && grant_if;
    d_req_ready  = rst && (state == IDLE) && d_req_valid && !grant_if;
    if_acc       = if_req_valid && if_req_ready;
    d_acc        = d_req_valid && d_req_ready;
  end

  // Capture mux: fetch requests are reads with no byte enables.
  always_comb begin
    req_nxt = req_q;
    if (if_acc) begin
      req_nxt = '{addr: MAX_AW'(if_addr), we: 1'b0, wdata: '0, wstrb: '0};
    end else if (d_acc) begin
      req_nxt = '{addr: MAX_AW'(d_addr), we: d_we, wdata: d_wdata, wstrb: d_wstrb};
    end
  end

  // Next-state logic for the IDLE -> ISSUE -> WAIT -> IDLE cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (if_acc || d_acc) state_nxt = ISSUE;
      ISSUE:   if (m_req_ready)     state_nxt = WAIT;
      WAIT:    if (m_rsp_valid)     state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Memory request and response routing; responses pass straight through.
  always_comb begin
    m_addr_full  = dw_align(req_q.addr);
    m_req_valid  = (state == ISSUE);
    m_addr       = m_addr_full[AW-1:0];
    m_we         = req_q.we;
    m_wdata      = req_q.wdata;
    m_wstrb      = req_q.wstrb;
    rsp_fire     = (state == WAIT) && m_rsp_valid;
    if_rsp_valid = rsp_fire && (owner == OWN_IF);
    d_rsp_valid  = rsp_fire && (owner == OWN_D);
    if_rsp_data  = '0;
    d_rsp_data   = '0;
    if (if_rsp_valid) if_rsp_data = req_q.addr[2] ? m_rsp_data[63:32] : m_rsp_data[31:0];
    if (d_rsp_valid && !req_q.we) d_rsp_data = m_rsp_data;
  end

  // State, captured request, starvation counter and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the capture register is reset too, so m_* fields read 0 during reset.
      state      <= IDLE;
      owner      <= OWN_IF;
      req_q      <= '0;
      starve_cnt <= '0;
      err        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state <= state_nxt;
      req_q <= req_nxt;
      if (if_acc)     owner <= OWN_IF;
      else if (d_acc) owner <= OWN_D;
      if (if_acc) begin
        starve_cnt <= '0;
      end else if (if_req_valid && !if_req_ready && starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
      if (m_rsp_valid && state != WAIT) err <= 1'b1;
    end
  end

endmodule
